stream2vga: RTL

Pixel-stream to VGA-timing adapter for the DVI output path. It sits between a pixel producer (framebuffer reader, pattern engine) and `vga2dvid`. A valid/ready pixel stream with start-of-frame marking is buffered in a small FIFO. Pixels are then released in lock-step with the `vga` timing generator's blank and sync signals, so the output is RGB plus sync, aligned and ready for TMDS encoding. The block detects underrun and frame misalignment and resynchronises on the next frame.

---
 rtl/stream2vga_pkg.sv | 17 +
 rtl/stream2vga_sync_fifo.sv | 59 +++++
 rtl/stream2vga.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/stream2vga_pkg.sv
// stream2vga shared definitions: FSM states, fill colours and
// the FIFO word layout {sof, r, g, b}.
package stream2vga_pkg;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ARMED,
        ACTIVE
    } state_t;

    localparam logic [23:0] FILL_BLACK   = 24'h000000;
    localparam logic [23:0] FILL_MAGENTA = 24'hFF00FF;

    localparam int SOF_BIT = 24;
    localparam int WORD_W  = 25;

endpackage

// File: rtl/stream2vga_sync_fifo.sv
// Single-clock FIFO, no fall-through: a word written in cycle N
// is visible at the head from N+1. Head data is held in a register.
module sync_fifo #(
    parameter int W  = 25,
    parameter int AW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic [W-1:0] r_rdata;
    logic         w_push;
    logic         w_pop;
    logic [AW:0]  w_rd_next;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) &&
                       (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign w_rd_next = r_rd + {{AW{1'b0}}, w_pop};
    assign o_rdata   = r_rdata;

    // Storage array; contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointers and prefetched head word (bypass when head is being written).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_rdata <= '0;
        end else begin
            r_wr <= r_wr + {{AW{1'b0}}, w_push};
            r_rd <= w_rd_next;
            if (w_push && (r_wr == w_rd_next)) begin
                r_rdata <= i_wdata;
            end else begin
                r_rdata <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/stream2vga.sv
// Pixel stream to VGA timing adapter with underrun/misalignment resync.
// Build option: STREAM2VGA_FILL_MAGENTA_EN selects a magenta fill colour.
module stream2vga
    import stream2vga_pkg::*;
#(
    parameter int   C_fifo_bits    = 5,
    parameter logic C_vsync_active = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_blank,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_blank,
    output logic        underrun
);

`ifdef STREAM2VGA_FILL_MAGENTA_EN
    localparam logic [23:0] FILL = FILL_MAGENTA;
`else
    localparam logic [23:0] FILL = FILL_BLACK;
`endif

    state_t              r_state;
    logic [23:0]         r_rgb;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_blank;
    logic                r_underrun;
    logic                r_pending;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic [WORD_W-1:0]   w_head;
    logic                w_head_sof;
    logic                w_active;
    logic                w_vs_edge;

    assign in_ready   = !w_full;
    assign w_active   = !in_blank;
    assign w_head_sof = w_head[SOF_BIT];
    assign w_vs_edge  = (in_vsync == C_vsync_active) &&
                        (r_vsync != C_vsync_active);

    sync_fifo #(
        .W  (WORD_W),
        .AW (C_fifo_bits)
    ) u_fifo (
        .clk     (clk_pixel),
        .rst_n   (rst_n),
        .i_push  (in_valid),
        .i_wdata ({in_sof, in_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pop decision: discards in WAIT_SOF, otherwise only on active cycles.
    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            WAIT_SOF: w_pop = !w_empty && !w_head_sof;
            ARMED:    w_pop = w_active && r_pending && !w_empty;
            ACTIVE:   w_pop = !w_vs_edge && w_active &&
                              !w_empty && !w_head_sof;
            default:  w_pop = 1'b0;
        endcase
    end

    // Timing delay line and frame-start tracking.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync   <= 1'b0;
            r_vsync   <= !C_vsync_active;
            r_blank   <= 1'b1;
            r_pending <= 1'b0;
        end else begin
            r_hsync <= in_hsync;
            r_vsync <= in_vsync;
            r_blank <= in_blank;
            if (w_vs_edge) begin
                r_pending <= 1'b1;
            end else if (w_active) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Frame alignment FSM with registered pixel and underrun outputs.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= WAIT_SOF;
            r_rgb      <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            r_rgb      <= w_active ? FILL : 24'h000000;
            unique case (r_state)
                WAIT_SOF: begin
                    if (!w_empty && w_head_sof) begin
                        r_state <= ARMED;
                    end
                end
                ARMED: begin
                    if (w_pop) begin
                        r_rgb   <= w_head[23:0];
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // A head carrying sof at vsync is a clean frame boundary.
                    if (w_vs_edge) begin
                        if (w_empty) begin
                            r_state <= WAIT_SOF;
                        end else if (w_head_sof) begin
                            r_state <= ARMED;
                        end else begin
                            r_state    <= WAIT_SOF;
                            r_underrun <= 1'b1;
                        end
                    end else if (w_active) begin
                        if (w_empty) begin
                            r_state    <= WAIT_SOF;
                            r_underrun <= 1'b1;
                        end else if (w_head_sof) begin
                            r_state    <= ARMED;
                            r_underrun <= 1'b1;
                        end else begin
                            r_rgb <= w_head[23:0];
                        end
                    end
                end
                default: r_state <= WAIT_SOF;
            endcase
        end
    end

    assign out_red   = r_rgb[23:16];
    assign out_green = r_rgb[15:8];
    assign out_blue  = r_rgb[7:0];
    assign out_hsync = r_hsync;
    assign out_vsync = r_vsync;
    assign out_blank = r_blank;
    assign underrun  = r_underrun;

endmodule
